u_imem: RTL and testbench

// - Instruction-memory responder for the fetch unit: serves the ins_a/ins_e read port, returns ins one cycle later.
// - Word-organised synchronous SRAM with a program-load port (valid/ready stream) behind a small load FSM.
// - Holds the core (core_hold) while a program image is being written.
// - Sits between the IFU and the boot/debug loader.

---
 rtl/u_imem_if.sv | 29 ++
 rtl/u_imem.sv | 138 +++++++++++++
 tb/tb_u_imem.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/u_imem_if.sv
// Fetch read port and program-load stream of the instruction memory.
// The slave side is the memory; the master side is the IFU plus the boot/debug loader.
interface u_imem_if #(
  parameter int AW = 10
);
  logic [15:0]   ins_a;
  logic          ins_e;
  logic [31:0]   ins;
  logic          ins_err;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_par_inv;
  logic          ld_ready;
  logic          ld_done;
  logic          core_hold;

  modport slave (
    input  ins_a, ins_e, ld_start, ld_base, ld_len, ld_valid, ld_data, ld_par_inv,
    output ins, ins_err, ld_ready, ld_done, core_hold
  );

  modport master (
    output ins_a, ins_e, ld_start, ld_base, ld_len, ld_valid, ld_data, ld_par_inv,
    input  ins, ins_err, ld_ready, ld_done, core_hold
  );
endinterface

// File: rtl/u_imem.sv
// Instruction memory: 1-cycle fetch port plus a valid/ready program-load port behind a load FSM.
// Optional per-word even parity is enabled with the IMEM_PARITY_EN macro.
//
// state | meaning
// RUN   | normal fetch; load port idle, core running
// LOAD  | accepting load words, core held, fetches return NOP_INS
// DONE  | one-cycle ld_done pulse, core still held
module u_imem #(
  parameter int          AW      = 10,
  parameter logic [31:0] NOP_INS = 32'h0000_0013
) (
  input logic    clk,
  input logic    rstn,
  u_imem_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] wptr, wptr_nx;
  logic [AW:0]   cnt, cnt_nx;
  logic [AW:0]   len_clamp;
  logic          wr_en;
  logic [AW-1:0] rd_idx;
  logic          rd_perr;
  logic [31:0]   ins_q;
  logic          ins_err_q;

  logic [31:0]   mem [DEPTH];

  assign rd_idx    = bus.ins_a[AW+1:2];
  assign len_clamp = (bus.ld_len > LEN_MAX) ? LEN_MAX : bus.ld_len;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_RUN;
      wptr  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      wptr  <= wptr_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    wptr_nx       = wptr;
    cnt_nx        = cnt;
    wr_en         = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.ld_done   = 1'b0;
    bus.core_hold = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.ld_start && (bus.ld_len != '0)) begin
          state_nx = ST_LOAD;
          wptr_nx  = bus.ld_base;
          cnt_nx   = len_clamp;
        end
      end
      ST_LOAD: begin
        bus.ld_ready  = 1'b1;
        bus.core_hold = 1'b1;
        if (bus.ld_valid) begin
          wr_en   = 1'b1;
          wptr_nx = wptr + 1'b1;
          cnt_nx  = cnt - 1'b1;
          if (cnt == {{AW{1'b0}}, 1'b1}) begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        bus.ld_done   = 1'b1;
        bus.core_hold = 1'b1;
        state_nx      = ST_RUN;
      end
      default: begin
        state_nx = ST_RUN;
      end
    endcase
  end

  // Array is deliberately not reset so a loaded image survives rstn.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= bus.ld_data;
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_mem[wptr] <= (^bus.ld_data) ^ bus.ld_par_inv;
    end
  end

  assign rd_perr = (^mem[rd_idx]) ^ par_mem[rd_idx];

  logic unused_bits;
  assign unused_bits = ^{bus.ins_a[15:AW+2], bus.ins_a[1:0]};
`else
  assign rd_perr = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bus.ins_a[15:AW+2], bus.ins_a[1:0], bus.ld_par_inv};
`endif

  // Reads are only issued in RUN, so they never collide with a load write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ins_q     <= NOP_INS;
      ins_err_q <= 1'b0;
    end else begin
      ins_err_q <= 1'b0;
      if (bus.ins_e) begin
        if (state == ST_RUN) begin
          ins_q     <= mem[rd_idx];
          ins_err_q <= rd_perr;
        end else begin
          ins_q <= NOP_INS;
        end
      end
    end
  end

  assign bus.ins     = ins_q;
  assign bus.ins_err = ins_err_q;
endmodule

// File: tb/tb_u_imem.sv
// Bench for u_imem: directed load/read scenarios plus random loads and fetches
// checked against a word-array reference model.
module tb_u_imem;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  u_imem_if #(.AW(AW)) bus ();
  u_imem #(.AW(AW), .NOP_INS(NOP)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem  [DEPTH];
  bit          ref_perr [DEPTH];
  logic [31:0] exp_ins = NOP;
  bit          exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input bit en);
    int idx;
    bus.ins_a = a;
    bus.ins_e = en;
    tick();
    idx = (int'(a) / 4) % DEPTH;
    if (en) begin
      exp_ins = ref_mem[idx];
      exp_err = ref_perr[idx];
    end else begin
      exp_err = 1'b0;
    end
    chk("ins", bus.ins, exp_ins);
    chk("ins_err", {31'd0, bus.ins_err}, {31'd0, exp_err});
    bus.ins_e = 1'b0;
  endtask

  // stop_after >= 0 abandons the load after that many written words (still in LOAD).
  task automatic load(input int base, input int len, input int gap_pct,
                      input int stop_after, input bit pinv,
                      input bit use_pat, input logic [7:0] pat);
    int eff, wp, n, c;
    bit v;
    logic [31:0] d;
    bus.ld_start = 1'b1;
    bus.ld_base  = base[AW-1:0];
    bus.ld_len   = len[AW:0];
    tick();
    bus.ld_start = 1'b0;
    if (len == 0) begin
      chk("len0_hold", {31'd0, bus.core_hold}, 32'd0);
      chk("len0_ready", {31'd0, bus.ld_ready}, 32'd0);
      return;
    end
    eff = (len > DEPTH) ? DEPTH : len;
    wp  = base % DEPTH;
    n   = 0;
    c   = 0;
    while (n < eff) begin
      if (stop_after >= 0 && n == stop_after) return;
      chk("ld_ready", {31'd0, bus.ld_ready}, 32'd1);
      chk("core_hold", {31'd0, bus.core_hold}, 32'd1);
      chk("ld_done_early", {31'd0, bus.ld_done}, 32'd0);
      v = use_pat ? pat[c % 8] : ($urandom_range(99) >= gap_pct);
      d = $urandom;
      bus.ld_valid   = v;
      bus.ld_data    = d;
      bus.ld_par_inv = pinv;
      bus.ins_e      = $urandom_range(1);
      bus.ins_a      = 16'($urandom);
      tick();
      if (bus.ins_e) exp_ins = NOP;
      chk("ins_in_load", bus.ins, exp_ins);
      chk("err_in_load", {31'd0, bus.ins_err}, 32'd0);
      if (v) begin
        ref_mem[wp]  = d;
        ref_perr[wp] = pinv;
        wp = (wp + 1) % DEPTH;
        n++;
      end
      c++;
    end
    bus.ld_valid = 1'b0;
    bus.ins_e    = 1'b0;
    chk("ld_done", {31'd0, bus.ld_done}, 32'd1);
    chk("done_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("done_hold", {31'd0, bus.core_hold}, 32'd1);
    tick();
    chk("done_pulse_end", {31'd0, bus.ld_done}, 32'd0);
    chk("run_hold", {31'd0, bus.core_hold}, 32'd0);
    chk("run_ready", {31'd0, bus.ld_ready}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int saved0;
    bus.ins_a = '0; bus.ins_e = 1'b0; bus.ld_start = 1'b0; bus.ld_base = '0;
    bus.ld_len = '0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_par_inv = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_perr[i] = 1'b0;

    // Reset state
    #12;
    chk("rst_ins", bus.ins, NOP);
    chk("rst_err", {31'd0, bus.ins_err}, 32'd0);
    chk("rst_hold", {31'd0, bus.core_hold}, 32'd0);
    chk("rst_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("rst_done", {31'd0, bus.ld_done}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Oversized length clamps to DEPTH and fills the whole array (with wrap)
    load(5, 2047, 0, -1, 1'b0, 1'b0, 8'h00);

    // Contents survive a reset; first read of idx 0
    @(negedge clk);
    rstn = 1'b0;
    #2;
    chk("rst2_ins", bus.ins, NOP);
    @(negedge clk);
    rstn = 1'b1;
    exp_ins = NOP;
    rd(16'h0000, 1'b1);
    rd(16'h0004, 1'b0);

    // Back-to-back load of 4 words at base 0, read back in address order
    load(0, 4, 0, -1, 1'b0, 1'b0, 8'h00);
    rd(16'h0000, 1'b1);
    rd(16'h0004, 1'b1);
    rd(16'h0008, 1'b1);
    rd(16'h000c, 1'b1);

    // Gap pattern 1,0,0,1,1 with len 3: word after the range must be untouched
    load(103, 1, 0, -1, 1'b0, 1'b0, 8'h00);
    load(100, 3, 0, -1, 1'b0, 1'b1, 8'b0001_1001);
    for (int i = 100; i < 104; i++) rd(16'(i * 4), 1'b1);

    // Wrap from DEPTH-1 to 0 and aliased fetch addresses
    load(DEPTH - 1, 2, 0, -1, 1'b0, 1'b0, 8'h00);
    rd(16'((DEPTH - 1) * 4), 1'b1);
    rd(16'h0000, 1'b1);
    rd(16'h1000, 1'b1);
    rd(16'h1003, 1'b1);

    // Reset after 2 of 5 words: back to RUN, no ld_done, written words kept
    saved0 = 0;
    load(200, 5, 0, 2, 1'b0, 1'b0, 8'h00);
    bus.ld_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #2;
    exp_ins = NOP;
    chk("mid_rst_hold", {31'd0, bus.core_hold}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("mid_rst_ins", bus.ins, NOP);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.ld_done) saved0++;
      chk("mid_rst_run", {31'd0, bus.core_hold}, 32'd0);
    end
    chk("mid_rst_no_done", saved0, 32'd0);
    rd(16'd800, 1'b1);
    rd(16'd804, 1'b1);

    // Zero length start is ignored
    load(50, 0, 0, -1, 1'b0, 1'b0, 8'h00);
    rd(16'd200, 1'b1);

    // Random loads interleaved with random fetches
    for (int k = 0; k < 8; k++) begin
      load($urandom_range(DEPTH - 1), $urandom_range(1, 12), 30, -1, 1'b0, 1'b0, 8'h00);
      for (int j = 0; j < 20; j++) begin
        idx = $urandom_range(DEPTH - 1);
        rd(16'(($urandom_range(15) << 12) | (idx << 2) | $urandom_range(3)),
           bit'($urandom_range(3) != 0));
      end
    end

`ifdef IMEM_PARITY_EN
    // Injected parity fault is reported, then cleared by a clean rewrite
    load(300, 1, 0, -1, 1'b1, 1'b0, 8'h00);
    rd(16'd1200, 1'b1);
    chk("par_flag", {31'd0, bus.ins_err}, 32'd1);
    rd(16'd1200, 1'b0);
    load(300, 1, 0, -1, 1'b0, 1'b0, 8'h00);
    rd(16'd1200, 1'b1);
    chk("par_clear", {31'd0, bus.ins_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
